// File: rtl/edge_detector_array.sv
// N-channel input conditioner: optional synchroniser, debounce filter, edge pulses
// (Mealy or Moore), sticky flags and saturating rising-edge counters per channel.
module edge_detector_array #(
  parameter int N           = 4,
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE    = 0,
  parameter int MOORE       = 0,
  parameter int CNT_W       = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         in,
  input  logic                 clear,
  output logic [N-1:0]         level,
  output logic [N-1:0]         positive_edge,
  output logic [N-1:0]         negative_edge,
  output logic [N-1:0]         sticky_pos,
  output logic [N-1:0]         sticky_neg,
  output logic [N*CNT_W-1:0]   pos_count
);

  localparam int DW = (DEBOUNCE > 0) ? $clog2(DEBOUNCE + 1) : 1;

  logic [N-1:0] sync;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign sync = in;
    end else begin : g_sync
      logic [N-1:0] sync_q [SYNC_STAGES];
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
        end else begin
          sync_q[0] <= in;
          for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
        end
      end
      assign sync = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  logic [N-1:0]     level_q, level_d;
  logic [DW-1:0]    cnt_q [N];
  logic [DW-1:0]    cnt_d [N];
  logic [N-1:0]     sticky_pos_q, sticky_pos_d;
  logic [N-1:0]     sticky_neg_q, sticky_neg_d;
  logic [CNT_W-1:0] pcnt_q [N];
  logic [CNT_W-1:0] pcnt_d [N];
  logic [N-1:0]     accept, rise, fall;

  always_comb begin
    level_d      = level_q;
    sticky_pos_d = sticky_pos_q;
    sticky_neg_d = sticky_neg_q;
    accept       = '0;
    rise         = '0;
    fall         = '0;
    for (int i = 0; i < N; i++) begin
      cnt_d[i]  = cnt_q[i];
      pcnt_d[i] = pcnt_q[i];
      // Gated by rst so no combinational pulse leaks while the block is held in reset.
      accept[i] = ~rst && (sync[i] != level_q[i]) && (cnt_q[i] == DW'(DEBOUNCE));
      rise[i]   = accept[i] & sync[i];
      fall[i]   = accept[i] & ~sync[i];
      if (sync[i] == level_q[i]) begin
        cnt_d[i] = '0;
      end else if (accept[i]) begin
        level_d[i] = sync[i];
        cnt_d[i]   = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + DW'(1);
      end
      // A clear coinciding with an accepted edge keeps that edge.
      if (clear) begin
        sticky_pos_d[i] = rise[i];
        sticky_neg_d[i] = fall[i];
        pcnt_d[i]       = CNT_W'(rise[i]);
      end else begin
        sticky_pos_d[i] = sticky_pos_q[i] | rise[i];
        sticky_neg_d[i] = sticky_neg_q[i] | fall[i];
        if (rise[i] && (pcnt_q[i] != {CNT_W{1'b1}})) pcnt_d[i] = pcnt_q[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_q      <= '0;
      sticky_pos_q <= '0;
      sticky_neg_q <= '0;
      for (int i = 0; i < N; i++) begin
        cnt_q[i]  <= '0;
        pcnt_q[i] <= '0;
      end
    end else begin
      level_q      <= level_d;
      sticky_pos_q <= sticky_pos_d;
      sticky_neg_q <= sticky_neg_d;
      for (int i = 0; i < N; i++) begin
        cnt_q[i]  <= cnt_d[i];
        pcnt_q[i] <= pcnt_d[i];
      end
    end
  end

  generate
    if (MOORE != 0) begin : g_moore
      logic [N-1:0] pos_pulse_q, neg_pulse_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          pos_pulse_q <= '0;
          neg_pulse_q <= '0;
        end else begin
          pos_pulse_q <= rise;
          neg_pulse_q <= fall;
        end
      end
      assign positive_edge = pos_pulse_q;
      assign negative_edge = neg_pulse_q;
    end else begin : g_mealy
      assign positive_edge = rise;
      assign negative_edge = fall;
    end
  endgenerate

  assign level      = level_q;
  assign sticky_pos = sticky_pos_q;
  assign sticky_neg = sticky_neg_q;

  always_comb begin
    pos_count = '0;
    for (int i = 0; i < N; i++) pos_count[i*CNT_W +: CNT_W] = pcnt_q[i];
  end

endmodule

// File: tb/tb_edge_detector_array.sv
// Bench for edge_detector_array: four configurations checked every cycle against a
// window-based behavioural model, plus directed literal checks of key timing points.
module tb_edge_detector_array;

  logic clk = 1'b0;
  logic rst;
  logic clear;
  logic [3:0] in_a, in_b, in_c, in_d;
  logic [3:0] lvl_a, pe_a, ne_a, sp_a, sn_a;
  logic [3:0] lvl_b, pe_b, ne_b, sp_b, sn_b;
  logic [3:0] lvl_c, pe_c, ne_c, sp_c, sn_c;
  logic [3:0] lvl_d, pe_d, ne_d, sp_d, sn_d;
  logic [31:0] pc_a;
  logic [11:0] pc_b;
  logic [15:0] pc_c;
  logic [7:0]  pc_d;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // A: Mealy, sync 2, no debounce. B: Moore, debounce 3, 3-bit counters.
  // C: Moore twin of A. D: sync bypass, debounce 1, Mealy, 2-bit counters.
  edge_detector_array #(.N(4), .SYNC_STAGES(2), .DEBOUNCE(0), .MOORE(0), .CNT_W(8)) u_a (
    .clk(clk), .rst(rst), .in(in_a), .clear(clear), .level(lvl_a), .positive_edge(pe_a),
    .negative_edge(ne_a), .sticky_pos(sp_a), .sticky_neg(sn_a), .pos_count(pc_a));
  edge_detector_array #(.N(4), .SYNC_STAGES(2), .DEBOUNCE(3), .MOORE(1), .CNT_W(3)) u_b (
    .clk(clk), .rst(rst), .in(in_b), .clear(clear), .level(lvl_b), .positive_edge(pe_b),
    .negative_edge(ne_b), .sticky_pos(sp_b), .sticky_neg(sn_b), .pos_count(pc_b));
  edge_detector_array #(.N(4), .SYNC_STAGES(2), .DEBOUNCE(0), .MOORE(1), .CNT_W(4)) u_c (
    .clk(clk), .rst(rst), .in(in_c), .clear(clear), .level(lvl_c), .positive_edge(pe_c),
    .negative_edge(ne_c), .sticky_pos(sp_c), .sticky_neg(sn_c), .pos_count(pc_c));
  edge_detector_array #(.N(4), .SYNC_STAGES(0), .DEBOUNCE(1), .MOORE(0), .CNT_W(2)) u_d (
    .clk(clk), .rst(rst), .in(in_d), .clear(clear), .level(lvl_d), .positive_edge(pe_d),
    .negative_edge(ne_d), .sticky_pos(sp_d), .sticky_neg(sn_d), .pos_count(pc_d));

  int cs[4] = '{2, 2, 2, 0};
  int cd[4] = '{0, 3, 0, 1};
  int cm[4] = '{0, 1, 1, 0};
  int cw[4] = '{8, 3, 4, 2};

  // Model: inputs of every cycle since reset, plus the observable per-channel state.
  logic [15:0] hist[$];
  logic [3:0]  m_lvl[4], m_sp[4], m_sn[4], m_mp[4], m_mn[4];
  int          m_cnt[4][4];
  logic [3:0]  cur_acc[4], cur_sync[4];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic sync_at(int i, int ch, int c);
    logic [15:0] v;
    if (cs[i] == 0) begin
      v = hist[c];
      return v[i*4+ch];
    end
    if (c < cs[i]) return 1'b0;
    v = hist[c-cs[i]];
    return v[i*4+ch];
  endfunction

  // A change is accepted once the filtered input has differed from the level on
  // each of the last DEBOUNCE+1 cycles since reset.
  function automatic logic acc_at(int i, int ch, int c);
    for (int j = 0; j <= cd[i]; j++) begin
      if (c - j < 0) return 1'b0;
      if (sync_at(i, ch, c - j) == m_lvl[i][ch]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic check_inst(input int i, input logic [3:0] lv, pe, ne, sp, sn,
                            input logic [31:0] pc);
    logic [3:0]  epe, ene;
    logic [31:0] epc;
    epe = (cm[i] != 0) ? m_mp[i] : (cur_acc[i] & cur_sync[i]);
    ene = (cm[i] != 0) ? m_mn[i] : (cur_acc[i] & ~cur_sync[i]);
    epc = '0;
    for (int ch = 0; ch < 4; ch++) epc |= 32'(m_cnt[i][ch]) << (ch * cw[i]);
    chk($sformatf("inst%0d_level", i), 32'(lv), 32'(m_lvl[i]));
    chk($sformatf("inst%0d_pos_edge", i), 32'(pe), 32'(epe));
    chk($sformatf("inst%0d_neg_edge", i), 32'(ne), 32'(ene));
    chk($sformatf("inst%0d_sticky_pos", i), 32'(sp), 32'(m_sp[i]));
    chk($sformatf("inst%0d_sticky_neg", i), 32'(sn), 32'(m_sn[i]));
    chk($sformatf("inst%0d_pos_count", i), pc, epc);
  endtask

  task automatic update_model(input int i, input logic clr);
    logic a, s, r, f;
    for (int ch = 0; ch < 4; ch++) begin
      a = cur_acc[i][ch];
      s = cur_sync[i][ch];
      r = a & s;
      f = a & ~s;
      if (a) m_lvl[i][ch] = s;
      m_mp[i][ch] = r;
      m_mn[i][ch] = f;
      if (clr) begin
        m_sp[i][ch]  = r;
        m_sn[i][ch]  = f;
        m_cnt[i][ch] = int'(r);
      end else begin
        m_sp[i][ch] = m_sp[i][ch] | r;
        m_sn[i][ch] = m_sn[i][ch] | f;
        if (r && m_cnt[i][ch] < (1 << cw[i]) - 1) m_cnt[i][ch]++;
      end
    end
  endtask

  always @(negedge clk) begin
    int c;
    if (rst) begin
      hist.delete();
      for (int i = 0; i < 4; i++) begin
        m_lvl[i] = '0; m_sp[i] = '0; m_sn[i] = '0; m_mp[i] = '0; m_mn[i] = '0;
        cur_acc[i] = '0; cur_sync[i] = '0;
        for (int ch = 0; ch < 4; ch++) m_cnt[i][ch] = 0;
      end
    end else begin
      hist.push_back({in_d, in_c, in_b, in_a});
      c = hist.size() - 1;
      for (int i = 0; i < 4; i++)
        for (int ch = 0; ch < 4; ch++) begin
          cur_sync[i][ch] = sync_at(i, ch, c);
          cur_acc[i][ch]  = acc_at(i, ch, c);
        end
    end
    check_inst(0, lvl_a, pe_a, ne_a, sp_a, sn_a, pc_a);
    check_inst(1, lvl_b, pe_b, ne_b, sp_b, sn_b, 32'(pc_b));
    check_inst(2, lvl_c, pe_c, ne_c, sp_c, sn_c, 32'(pc_c));
    check_inst(3, lvl_d, pe_d, ne_d, sp_d, sn_d, 32'(pc_d));
    if (!rst) for (int i = 0; i < 4; i++) update_model(i, clear);
  end

  task automatic step(input logic [3:0] a, b, c, d, input logic clr);
    @(posedge clk);
    #1;
    in_a = a; in_b = b; in_c = c; in_d = d; clear = clr;
    @(negedge clk);
    #1;
  endtask

  // Asserts reset between edges, checks outputs drop at once, releases just after an edge.
  task automatic do_reset(input logic [3:0] a, b, c, d, input int n);
    @(posedge clk);
    #3;
    rst = 1'b1;
    in_a = a; in_b = b; in_c = c; in_d = d; clear = 1'b0;
    #1;
    chk("rst_now_a", {12'(0), lvl_a, pe_a, ne_a, sp_a, sn_a} | pc_a, 32'h0);
    chk("rst_now_b", {8'(0), lvl_b, pe_b, ne_b, sp_b, sn_b, pc_b}, 32'h0);
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] ra, rb, rc, rd;
    int rate;
    rst = 1'b1; clear = 1'b0;
    in_a = '0; in_b = '0; in_c = '0; in_d = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    #1;
    chk("idle_after_reset", {12'(0), lvl_a, pe_a, ne_a, sp_a, sn_a} | pc_a, 32'h0);

    // Rise on channel 0 of A (Mealy) and C (Moore).
    step(4'b0001, 4'b0, 4'b0001, 4'b0, 1'b0);
    step(4'b0001, 4'b0, 4'b0001, 4'b0, 1'b0);
    step(4'b0001, 4'b0, 4'b0001, 4'b0, 1'b0);
    chk("a_rise_pulse", 32'(pe_a), 32'h1);
    chk("a_level_before_flip", 32'(lvl_a), 32'h0);
    chk("c_no_pulse_yet", 32'(pe_c), 32'h0);
    step(4'b0001, 4'b0, 4'b0001, 4'b0, 1'b0);
    chk("a_pulse_done", 32'(pe_a), 32'h0);
    chk("a_level_high", 32'(lvl_a), 32'h1);
    chk("a_count_one", pc_a, 32'h1);
    chk("a_sticky_pos", 32'(sp_a), 32'h1);
    chk("c_moore_pulse", 32'(pe_c), 32'h1);
    chk("c_moore_level", 32'(lvl_c), 32'h1);
    step(4'b0, 4'b0, 4'b0, 4'b0, 1'b0);
    step(4'b0, 4'b0, 4'b0, 4'b0, 1'b0);
    step(4'b0, 4'b0, 4'b0, 4'b0, 1'b0);
    chk("a_fall_pulse", 32'(ne_a), 32'h1);
    step(4'b0, 4'b0, 4'b0, 4'b0, 1'b0);
    chk("c_moore_fall", 32'(ne_c), 32'h1);
    chk("c_level_low", 32'(lvl_c), 32'h0);
    chk("c_sticky_neg", 32'(sn_c), 32'h1);

    // Debounce on B channel 1: a 3-cycle pulse must be rejected.
    repeat (3) step(4'b0, 4'b0010, 4'b0, 4'b0, 1'b0);
    repeat (6) step(4'b0, 4'b0, 4'b0, 4'b0, 1'b0);
    chk("b_short_level", 32'(lvl_b), 32'h0);
    chk("b_short_sticky", 32'(sp_b), 32'h0);
    repeat (7) step(4'b0, 4'b0010, 4'b0, 4'b0, 1'b0);
    chk("b_long_pulse", 32'(pe_b), 32'h2);
    chk("b_long_level", 32'(lvl_b), 32'h2);
    step(4'b0, 4'b0010, 4'b0, 4'b0, 1'b0);
    chk("b_single_pulse", 32'(pe_b), 32'h0);
    chk("b_count", 32'(pc_b), 32'h8);
    // Falling with a one-cycle glitch back high restarts the count.
    step(4'b0, 4'b0, 4'b0, 4'b0, 1'b0);
    step(4'b0, 4'b0, 4'b0, 4'b0, 1'b0);
    step(4'b0, 4'b0010, 4'b0, 4'b0, 1'b0);
    repeat (6) step(4'b0, 4'b0, 4'b0, 4'b0, 1'b0);
    chk("b_glitch_no_fall_yet", 32'(ne_b), 32'h0);
    step(4'b0, 4'b0, 4'b0, 4'b0, 1'b0);
    chk("b_glitch_fall", 32'(ne_b), 32'h2);
    // Toggling every cycle never survives a debounce of 3.
    for (int k = 0; k < 20; k++) step(4'b0, (k % 2) ? 4'b1000 : 4'b0, 4'b0, 4'b0, 1'b0);
    repeat (4) step(4'b0, 4'b0, 4'b0, 4'b0, 1'b0);
    chk("b_toggle_no_event", 32'({sp_b[3], sn_b[3], lvl_b[3]}), 32'h0);

    // Saturation of B channel 2 (3-bit counter) and clear.
    for (int k = 0; k < 9; k++) begin
      repeat (6) step(4'b0, 4'b0100, 4'b0, 4'b0, 1'b0);
      repeat (6) step(4'b0, 4'b0, 4'b0, 4'b0, 1'b0);
    end
    chk("b_saturated", 32'(pc_b[8:6]), 32'h7);
    step(4'b0, 4'b0, 4'b0, 4'b0, 1'b1);
    step(4'b0, 4'b0, 4'b0, 4'b0, 1'b0);
    chk("b_cleared_count", 32'(pc_b), 32'h0);
    chk("b_cleared_sticky", 32'({sp_b, sn_b}), 32'h0);

    // Clear in the same cycle as an accepted rise on A channel 3.
    step(4'b1000, 4'b0, 4'b0, 4'b0, 1'b0);
    step(4'b1000, 4'b0, 4'b0, 4'b0, 1'b0);
    step(4'b1000, 4'b0, 4'b0, 4'b0, 1'b1);
    step(4'b1000, 4'b0, 4'b0, 4'b0, 1'b0);
    chk("a_clear_race_count", 32'(pc_a[31:24]), 32'h1);
    chk("a_clear_race_sticky", 32'(sp_a), 32'h8);
    repeat (4) step(4'b0, 4'b0, 4'b0, 4'b0, 1'b0);
    step(4'b1111, 4'b0, 4'b0, 4'b0, 1'b0);
    step(4'b1111, 4'b0, 4'b0, 4'b0, 1'b0);
    step(4'b1111, 4'b0, 4'b0, 4'b0, 1'b0);
    chk("a_all_rise", 32'(pe_a), 32'hf);

    // Reset in the middle of a B debounce: no event afterwards.
    step(4'b0, 4'b0001, 4'b0, 4'b0, 1'b0);
    step(4'b0, 4'b0001, 4'b0, 4'b0, 1'b0);
    step(4'b0, 4'b0001, 4'b0, 4'b0, 1'b0);
    do_reset(4'b0, 4'b0, 4'b0, 4'b0, 2);
    repeat (8) step(4'b0, 4'b0, 4'b0, 4'b0, 1'b0);
    chk("b_abort_no_event", 32'({sp_b, pc_b}), 32'h0);

    // Inputs held high through reset give exactly one rise each.
    do_reset(4'b1111, 4'b0, 4'b0, 4'b1111, 2);
    repeat (6) step(4'b1111, 4'b0, 4'b0, 4'b1111, 1'b0);
    chk("a_high_through_reset", pc_a, 32'h01010101);
    chk("d_high_through_reset", 32'(pc_d), 32'h55);

    // Randomised traffic, alternating fast and slow toggling regimes.
    ra = '0; rb = '0; rc = '0; rd = '0;
    for (int blk = 0; blk < 15; blk++) begin
      rate = (blk % 2) ? 2 : $urandom_range(5, 12);
      for (int k = 0; k < 200; k++) begin
        for (int b = 0; b < 4; b++) begin
          if ($urandom_range(0, rate - 1) == 0) ra[b] = ~ra[b];
          if ($urandom_range(0, rate - 1) == 0) rb[b] = ~rb[b];
          if ($urandom_range(0, rate - 1) == 0) rc[b] = ~rc[b];
          if ($urandom_range(0, rate - 1) == 0) rd[b] = ~rd[b];
        end
        if ($urandom_range(0, 399) == 0)
          do_reset(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 1);
        else
          step(ra, rb, rc, rd, $urandom_range(0, 39) == 0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
